// File: rtl/serdes_pkg.sv
// Shared types and constants for the serdes receive path.
// The SERDES_RX_PARITY_EN macro selects 9-strobe symbols that carry an even-parity bit.
package serdes_pkg;

    typedef enum logic [1:0] {
        HUNT  = 2'd0,
        DATA  = 2'd1,
        CHECK = 2'd2
    } rx_state_t;

    typedef struct packed {
        logic       sof;
        logic [7:0] data;
    } rx_byte_t;

    localparam logic [7:0] SYNC_WORD_DEFAULT = 8'hBC;

`ifdef SERDES_RX_PARITY_EN
    localparam int unsigned SYM_LEN = 9;
`else
    localparam int unsigned SYM_LEN = 8;
`endif

    localparam int unsigned BIT_CNT_W  = 4;
    localparam int unsigned BYTE_CNT_W = 8;
    localparam int unsigned MISS_CNT_W = 4;

endpackage

// File: rtl/serdes_rx_fifo.sv
// Show-ahead synchronous FIFO of {sof, byte} entries with a sticky overflow flag.
module serdes_rx_fifo
    import serdes_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     push_i,
    input  rx_byte_t wdata_i,
    input  logic     ready_i,
    output rx_byte_t rdata_o,
    output logic     valid_o,
    output logic     overflow_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    rx_byte_t         mem_q [DEPTH];
    logic [PTR_W:0]   wr_q;
    logic [PTR_W:0]   rd_q;
    logic             overflow_q;
    logic             empty_c;
    logic             full_c;
    logic             pop_c;
    logic             wr_en_c;

    // The extra MSB on each pointer separates full from empty.
    assign empty_c = (wr_q == rd_q);
    assign full_c  = (wr_q[PTR_W] != rd_q[PTR_W]) &&
                     (wr_q[PTR_W-1:0] == rd_q[PTR_W-1:0]);
    assign pop_c   = ready_i && !empty_c;
    assign wr_en_c = push_i && (!full_c || pop_c);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_q       <= '0;
            rd_q       <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (wr_en_c) begin
                wr_q <= wr_q + (PTR_W+1)'(1);
            end
            if (pop_c) begin
                rd_q <= rd_q + (PTR_W+1)'(1);
            end
            if (push_i && full_c && !pop_c) begin
                overflow_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en_c) begin
            mem_q[wr_q[PTR_W-1:0]] <= wdata_i;
        end
    end

    assign rdata_o    = empty_c ? '0 : mem_q[rd_q[PTR_W-1:0]];
    assign valid_o    = !empty_c;
    assign overflow_o = overflow_q;

endmodule

// File: rtl/serdes_frame_rx.sv
// Serial frame receiver: sync hunt, flywheel lock, byte deserialisation into an output FIFO.
// Build with SERDES_RX_PARITY_EN for 9-bit symbols carrying even parity.
module serdes_frame_rx
    import serdes_pkg::*;
#(
    parameter logic [7:0]  SYNC_WORD   = SYNC_WORD_DEFAULT,
    parameter int unsigned PAYLOAD_LEN = 4,
    parameter int unsigned MAX_MISS    = 2,
    parameter int unsigned FIFO_DEPTH  = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ser_en,
    input  logic       ser_in,
    output logic [7:0] data_out,
    output logic       data_sof,
    output logic       data_valid,
    input  logic       data_ready,
    output logic       locked,
    output logic       overflow,
    output logic       parity_err
);

    rx_state_t               state_q, state_d;
    logic [SYM_LEN-1:0]      sreg_q, sreg_d;
    logic [BIT_CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic [BYTE_CNT_W-1:0]   byte_cnt_q, byte_cnt_d;
    logic [MISS_CNT_W-1:0]   miss_cnt_q, miss_cnt_d;
    logic                    locked_q, locked_d;

    logic [SYM_LEN-1:0]      sreg_nx;
    logic [BIT_CNT_W-1:0]    bit_nx;
    logic [MISS_CNT_W-1:0]   miss_nx;
    logic [7:0]              sym_data;
    logic                    sym_done;
    logic                    sym_ok;
    logic                    push_c;
    rx_byte_t                push_data_c;
    rx_byte_t                head;

    assign sreg_nx  = {sreg_q[SYM_LEN-2:0], ser_in};
    assign bit_nx   = bit_cnt_q + BIT_CNT_W'(1);
    assign miss_nx  = miss_cnt_q + MISS_CNT_W'(1);
    assign sym_data = sreg_nx[SYM_LEN-1 -: 8];
    assign sym_done = (bit_nx == BIT_CNT_W'(SYM_LEN));

`ifdef SERDES_RX_PARITY_EN
    logic hunt_par_q, hunt_par_d;
    logic parity_err_q, parity_err_d;
    assign sym_ok = (sym_data == SYNC_WORD) && !(^sreg_nx);
`else
    assign sym_ok = (sym_data == SYNC_WORD);
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= HUNT;
            sreg_q       <= '0;
            bit_cnt_q    <= '0;
            byte_cnt_q   <= '0;
            miss_cnt_q   <= '0;
            locked_q     <= 1'b0;
`ifdef SERDES_RX_PARITY_EN
            hunt_par_q   <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            sreg_q       <= sreg_d;
            bit_cnt_q    <= bit_cnt_d;
            byte_cnt_q   <= byte_cnt_d;
            miss_cnt_q   <= miss_cnt_d;
            locked_q     <= locked_d;
`ifdef SERDES_RX_PARITY_EN
            hunt_par_q   <= hunt_par_d;
            parity_err_q <= parity_err_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        sreg_d      = sreg_q;
        bit_cnt_d   = bit_cnt_q;
        byte_cnt_d  = byte_cnt_q;
        miss_cnt_d  = miss_cnt_q;
        locked_d    = locked_q;
        push_c      = 1'b0;
        push_data_c = '0;
`ifdef SERDES_RX_PARITY_EN
        hunt_par_d   = hunt_par_q;
        parity_err_d = 1'b0;
`endif
        if (ser_en) begin
            sreg_d = sreg_nx;
            case (state_q)
                HUNT: begin
                    // Counter saturates so a match needs 8 fresh bits since entering HUNT.
                    bit_cnt_d = (bit_cnt_q == BIT_CNT_W'(8)) ? bit_cnt_q : bit_nx;
`ifdef SERDES_RX_PARITY_EN
                    if (hunt_par_q) begin
                        hunt_par_d = 1'b0;
                        state_d    = DATA;
                        bit_cnt_d  = '0;
                        byte_cnt_d = '0;
                        miss_cnt_d = '0;
                        locked_d   = 1'b1;
                    end else if ((bit_cnt_d == BIT_CNT_W'(8)) && (sreg_nx[7:0] == SYNC_WORD)) begin
                        hunt_par_d = 1'b1;
                    end
`else
                    if ((bit_cnt_d == BIT_CNT_W'(8)) && (sreg_nx[7:0] == SYNC_WORD)) begin
                        state_d    = DATA;
                        bit_cnt_d  = '0;
                        byte_cnt_d = '0;
                        miss_cnt_d = '0;
                        locked_d   = 1'b1;
                    end
`endif
                end
                DATA: begin
                    if (sym_done) begin
                        bit_cnt_d        = '0;
                        push_c           = 1'b1;
                        push_data_c.data = sym_data;
                        push_data_c.sof  = (byte_cnt_q == '0);
`ifdef SERDES_RX_PARITY_EN
                        parity_err_d     = ^sreg_nx;
`endif
                        if (byte_cnt_q == BYTE_CNT_W'(PAYLOAD_LEN - 1)) begin
                            state_d    = CHECK;
                            byte_cnt_d = '0;
                        end else begin
                            byte_cnt_d = byte_cnt_q + BYTE_CNT_W'(1);
                        end
                    end else begin
                        bit_cnt_d = bit_nx;
                    end
                end
                CHECK: begin
                    if (sym_done) begin
                        bit_cnt_d = '0;
                        if (sym_ok) begin
                            miss_cnt_d = '0;
                            state_d    = DATA;
                        end else if (miss_nx == MISS_CNT_W'(MAX_MISS)) begin
                            miss_cnt_d = '0;
                            sreg_d     = '0;
                            locked_d   = 1'b0;
                            state_d    = HUNT;
                        end else begin
                            miss_cnt_d = miss_nx;
                            state_d    = DATA;
                        end
                    end else begin
                        bit_cnt_d = bit_nx;
                    end
                end
                default: begin
                    state_d = HUNT;
                end
            endcase
        end
    end

    serdes_rx_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push_i     (push_c),
        .wdata_i    (push_data_c),
        .ready_i    (data_ready),
        .rdata_o    (head),
        .valid_o    (data_valid),
        .overflow_o (overflow)
    );

    assign data_out = head.data;
    assign data_sof = head.sof;
    assign locked   = locked_q;

`ifdef SERDES_RX_PARITY_EN
    assign parity_err = parity_err_q;
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_serdes_frame_rx.sv
// Randomised bench for serdes_frame_rx: positional stream model plus cycle FIFO model.
module tb_serdes_frame_rx;

    localparam int unsigned PL = 4;
    localparam int unsigned MM = 2;
    localparam int unsigned FD = 4;
    localparam logic [7:0]  SW = 8'hBC;

    logic       clk = 1'b0;
    logic       rst_n, ser_en, ser_in, data_ready;
    logic [7:0] data_out;
    logic       data_sof, data_valid, locked, overflow, parity_err;

    always #5 clk = ~clk;

    serdes_frame_rx #(
        .SYNC_WORD   (SW),
        .PAYLOAD_LEN (PL),
        .MAX_MISS    (MM),
        .FIFO_DEPTH  (FD)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ser_en     (ser_en),
        .ser_in     (ser_in),
        .data_out   (data_out),
        .data_sof   (data_sof),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .locked     (locked),
        .overflow   (overflow),
        .parity_err (parity_err)
    );

    int checks   = 0;
    int failures = 0;

    // Stream under test and its offline expectation, indexed by strobe number.
    bit         bits [$];
    bit         lk [];
    bit         pv [];
    logic [7:0] pb [];
    bit         ps [];

    // Cycle model of the output buffer.
    logic [8:0] mq [$];
    bit         m_ovf;
    bit         m_lock;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s t=%0t got=%0h exp=%0h", name, $time, got, exp);
        end
    endtask

    function automatic logic [7:0] win(input int k);
        logic [7:0] v;
        v = '0;
        for (int t = 0; t < 8; t++) v = {v[6:0], bits[k+t]};
        return v;
    endfunction

    // Locate syncs and payload bytes by bit position over the whole stream.
    function automatic void analyze();
        int n, hs, found, p, q, miss, lost;
        n  = bits.size();
        lk = new[n];
        pv = new[n];
        pb = new[n];
        ps = new[n];
        hs = 0;
        while (1) begin
            found = -1;
            for (int k = hs + 7; k < n; k++) begin
                if (win(k - 7) == SW) begin
                    found = k;
                    break;
                end
            end
            if (found < 0) return;
            for (int k = found; k < n; k++) lk[k] = 1'b1;
            p    = found + 1;
            miss = 0;
            lost = -1;
            while (lost < 0) begin
                for (int j = 0; j < int'(PL); j++) begin
                    if (p + 8*j + 7 >= n) return;
                    pv[p + 8*j + 7] = 1'b1;
                    pb[p + 8*j + 7] = win(p + 8*j);
                    ps[p + 8*j + 7] = (j == 0);
                end
                q = p + 8*int'(PL);
                if (q + 7 >= n) return;
                if (win(q) == SW) miss = 0;
                else miss++;
                if (miss == int'(MM)) lost = q + 7;
                else p = q + 8;
            end
            for (int k = lost; k < n; k++) lk[k] = 1'b0;
            hs = lost + 1;
        end
    endfunction

    function automatic int npush();
        int c;
        c = 0;
        foreach (pv[k]) if (pv[k]) c++;
        return c;
    endfunction

    function automatic int first_push();
        foreach (pv[k]) if (pv[k]) return k;
        return -1;
    endfunction

    task automatic add_byte(input logic [7:0] b);
        for (int t = 7; t >= 0; t--) bits.push_back(b[t]);
    endtask

    task automatic add_rand_bits(input int n);
        for (int t = 0; t < n; t++) bits.push_back(1'($urandom_range(1)));
    endtask

    task automatic compare_outputs();
        chk("valid", data_valid, (mq.size() > 0));
        if (mq.size() > 0) begin
            chk("data", data_out, mq[0][7:0]);
            chk("sof", data_sof, mq[0][8]);
        end
        chk("locked", locked, m_lock);
        chk("overflow", overflow, m_ovf);
        chk("parity_err", parity_err, 1'b0);
    endtask

    // One clock: drive on negedge, update model at posedge, compare just after.
    task automatic step(input bit en, input bit rdy, input int s);
        bit pop;
        @(negedge clk);
        ser_en     = en;
        ser_in     = en ? bits[s] : 1'($urandom_range(1));
        data_ready = rdy;
        @(posedge clk);
        pop = (mq.size() > 0) && rdy;
        if (pop) void'(mq.pop_front());
        if (en) begin
            if (pv[s]) begin
                if (mq.size() < int'(FD)) mq.push_back({ps[s], pb[s]});
                else m_ovf = 1'b1;
            end
            m_lock = lk[s];
        end
        #1;
        compare_outputs();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n      = 1'b0;
        ser_en     = 1'b1;
        ser_in     = 1'b1;
        data_ready = 1'b1;
        @(posedge clk);
        mq.delete();
        m_ovf  = 1'b0;
        m_lock = 1'b0;
        #1;
        chk("rst_valid", data_valid, 1'b0);
        chk("rst_locked", locked, 1'b0);
        chk("rst_overflow", overflow, 1'b0);
        chk("rst_data", data_out, 8'h00);
        chk("rst_parity", parity_err, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // en_mode 0: strobe every cycle, 1: random strobes.
    // rdy_mode 0: random, 1: never, 2: always, 3: only at strobe rdy_at.
    task automatic run_seg(input int en_mode, input int rdy_mode, input int rdy_at, input int drain);
        int  s;
        bit  en, rdy;
        s = 0;
        while (s < bits.size()) begin
            en = (en_mode == 0) ? 1'b1 : ($urandom_range(3) != 0);
            case (rdy_mode)
                0:       rdy = ($urandom_range(1) == 1);
                1:       rdy = 1'b0;
                2:       rdy = 1'b1;
                default: rdy = en && (s == rdy_at);
            endcase
            step(en, rdy, s);
            if (en) s++;
        end
        for (int c = 0; c < drain; c++) step(1'b0, 1'b1, 0);
    endtask

    initial begin
        rst_n      = 1'b0;
        ser_en     = 1'b0;
        ser_in     = 1'b0;
        data_ready = 1'b0;

        // Basic framing with two frames.
        do_reset();
        bits.delete();
        add_byte(SW); add_byte(8'h11); add_byte(8'h22); add_byte(8'h33); add_byte(8'h44);
        add_byte(SW); add_byte(8'h55);
        analyze();
        chk("m1_lock6", lk[6], 1'b0);
        chk("m1_lock7", lk[7], 1'b1);
        chk("m1_push15", {ps[15], pb[15]}, 9'h111);
        chk("m1_push55", {ps[55], pb[55]}, 9'h155);
        chk("m1_npush", npush(), 5);
        run_seg(0, 2, 0, 6);

        // Misaligned sync after three random bits.
        do_reset();
        bits.delete();
        add_rand_bits(3);
        add_byte(SW); add_byte(8'hA1); add_byte(8'hA2); add_byte(8'hA3); add_byte(8'hA4);
        analyze();
        chk("m2_first", first_push(), 18);
        chk("m2_byte", {ps[18], pb[18]}, 9'h1A1);
        run_seg(1, 0, 0, 10);

        // Two bad syncs lose lock; flywheel frame still delivered, then relock.
        do_reset();
        bits.delete();
        add_byte(SW);
        for (int j = 0; j < 4; j++) add_byte(8'(8'h30 + j));
        add_byte(8'h00);
        for (int j = 0; j < 4; j++) add_byte(8'(8'h40 + j));
        add_byte(8'h00);
        add_byte(SW); add_byte(8'h51); add_byte(8'h52); add_byte(8'h53); add_byte(8'h54);
        analyze();
        chk("m3_lock86", lk[86], 1'b1);
        chk("m3_lock87", lk[87], 1'b0);
        chk("m3_fly", {ps[55], pb[55]}, 9'h140);
        chk("m3_npush", npush(), 12);
        run_seg(0, 0, 0, 10);

        // Overflow with consumer stalled, then drain.
        do_reset();
        bits.delete();
        add_byte(SW);
        for (int j = 1; j <= 4; j++) add_byte(8'(j));
        add_byte(SW); add_byte(8'h05); add_byte(8'h06);
        analyze();
        run_seg(0, 1, 0, 0);
        chk("m4_ovf", m_ovf, 1'b1);
        chk("m4_head", mq[0], 9'h101);
        chk("m4_tail", mq[3], 9'h004);
        for (int c = 0; c < 8; c++) step(1'b0, 1'b1, 0);

        // Push and pop on the same edge while full: no overflow.
        do_reset();
        bits.delete();
        add_byte(SW);
        for (int j = 1; j <= 4; j++) add_byte(8'(8'h60 + j));
        add_byte(SW); add_byte(8'h65);
        analyze();
        run_seg(0, 3, 55, 0);
        chk("m4b_ovf", m_ovf, 1'b0);
        chk("m4b_cnt", mq.size(), 4);
        for (int c = 0; c < 8; c++) step(1'b0, 1'b1, 0);

        // Reset mid-payload with two bytes buffered.
        do_reset();
        bits.delete();
        add_byte(SW); add_byte(8'h71); add_byte(8'h72);
        bits.push_back(1'b1); bits.push_back(1'b0); bits.push_back(1'b1);
        analyze();
        run_seg(0, 1, 0, 0);
        chk("m6_cnt", mq.size(), 2);
        chk("m6_valid_pre", data_valid, 1'b1);
        do_reset();
        bits.delete();
        add_byte(SW); add_byte(8'h81); add_byte(8'h82); add_byte(8'h83); add_byte(8'h84);
        analyze();
        run_seg(1, 0, 0, 10);

        // Random streams: random payloads, occasional bad syncs, random strobes and ready.
        for (int r = 0; r < 6; r++) begin
            do_reset();
            bits.delete();
            add_rand_bits(int'($urandom_range(12)));
            for (int f = 0; f < 6; f++) begin
                add_byte(($urandom_range(3) == 0) ? 8'($urandom) : SW);
                for (int j = 0; j < int'(PL); j++) add_byte(8'($urandom));
            end
            analyze();
            run_seg(1, (r % 2 == 0) ? 0 : 2, 0, 12);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
